// File: rtl/fpu_pattern_pkg.sv
// Shared state/opcode types and vector-slot layout for the FPU pattern player.
package fpu_pattern_pkg;

  // Slot fields {A,B,Sel,round,Yexp,ErrExp,OvfExp}; their widths sum to 102 bits
  localparam int unsigned VEC_W    = 102;
  localparam int unsigned OFF_OVF  = 0;
  localparam int unsigned OFF_ERR  = 1;
  localparam int unsigned OFF_YEXP = 2;
  localparam int unsigned OFF_RND  = 34;
  localparam int unsigned OFF_SEL  = 36;
  localparam int unsigned OFF_B    = 38;
  localparam int unsigned OFF_A    = 70;

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, CHECK, DONE} state_t;

  typedef enum logic [1:0] {ADD = 2'd0, SUB = 2'd1, MUL = 2'd2, DIV = 2'd3} sel_t;

endpackage

// File: rtl/fpu_pattern_mem.sv
// Vector store: DEPTH x VEC_W, one write port, one registered read port.
module fpu_pattern_mem
  import fpu_pattern_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [VEC_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [VEC_W-1:0] rd_data
);

  logic [VEC_W-1:0] mem [DEPTH];

  // Array is never reset so loaded vectors survive a reset
  always_ff @(posedge Clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fpu_pattern_player.sv
// Replays stored vectors into an FPU and scores results against expected values.
// Define FPU_PATTERN_FLAG_CHECK_EN to also score the Error/Overflow flags.
module fpu_pattern_player
  import fpu_pattern_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned AW      = 6,
  parameter int unsigned FPU_LAT = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [AW-1:0]    ld_addr,
  input  logic [VEC_W-1:0] ld_data,
  input  logic             go,
  input  logic [AW:0]      num_vec,
  input  logic             abort,
  output logic [31:0]      A,
  output logic [31:0]      B,
  output logic [1:0]       Sel,
  output logic [1:0]       round,
  output logic             start,
  input  logic [31:0]      Y,
  input  logic             Error,
  input  logic             Overflow,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      mis_cnt,
  output logic [AW-1:0]    fail_idx
);

  localparam int unsigned CW = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;
  localparam int unsigned NW = AW + 1;

  state_t           state;
  logic [AW-1:0]    idx;
  logic [AW-1:0]    last_idx;
  logic [CW-1:0]    wcnt;
  logic [31:0]      y_smp;
  logic             err_smp;
  logic             ovf_smp;
  logic [VEC_W-1:0] rd_data;
  logic             mism_c;

  fpu_pattern_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .Clock   (Clock),
    .Reset   (Reset),
    .wr_en   (ld_valid && ld_ready),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_en   ((state == FETCH) && !abort),
    .rd_addr (idx),
    .rd_data (rd_data)
  );

  // Operands come straight from the read register, which only moves on FETCH
  assign A     = rd_data[OFF_A +: 32];
  assign B     = rd_data[OFF_B +: 32];
  assign Sel   = rd_data[OFF_SEL +: 2];
  assign round = rd_data[OFF_RND +: 2];

`ifdef FPU_PATTERN_FLAG_CHECK_EN
  assign mism_c = (y_smp != rd_data[OFF_YEXP +: 32]) ||
                  (err_smp != rd_data[OFF_ERR]) || (ovf_smp != rd_data[OFF_OVF]);
`else
  assign mism_c = (y_smp != rd_data[OFF_YEXP +: 32]);
  logic unused_flags;
  assign unused_flags = ^{err_smp, ovf_smp, rd_data[OFF_ERR], rd_data[OFF_OVF]};
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      idx      <= '0;
      last_idx <= '0;
      wcnt     <= '0;
      y_smp    <= '0;
      err_smp  <= 1'b0;
      ovf_smp  <= 1'b0;
      start    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      ld_ready <= 1'b1;
      mis_cnt  <= '0;
      fail_idx <= '0;
    end else begin
      start <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        busy     <= 1'b0;
        done     <= 1'b0;
        pass     <= 1'b0;
        ld_ready <= 1'b1;
      end else begin
        unique case (state)
          IDLE, DONE: begin
            if (go) begin
              mis_cnt  <= '0;
              fail_idx <= '0;
              idx      <= '0;
              last_idx <= AW'(num_vec - NW'(1));
              if (num_vec == '0) begin
                state <= DONE;
                done  <= 1'b1;
                pass  <= 1'b1;
              end else begin
                state    <= FETCH;
                done     <= 1'b0;
                pass     <= 1'b0;
                busy     <= 1'b1;
                ld_ready <= 1'b0;
              end
            end
          end
          FETCH: begin
            state <= ISSUE;
            start <= 1'b1;
          end
          ISSUE: begin
            state <= WAIT;
            wcnt  <= CW'(FPU_LAT - 1);
          end
          WAIT: begin
            if (wcnt == '0) begin
              state   <= CHECK;
              y_smp   <= Y;
              err_smp <= Error;
              ovf_smp <= Overflow;
            end else begin
              wcnt <= wcnt - CW'(1);
            end
          end
          CHECK: begin
            if (mism_c) begin
              if (mis_cnt == '0) fail_idx <= idx;
              if (mis_cnt != 16'hFFFF) mis_cnt <= mis_cnt + 16'd1;
            end
            if (idx == last_idx) begin
              state    <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              ld_ready <= 1'b1;
              pass     <= (mis_cnt == '0) && !mism_c;
            end else begin
              state <= FETCH;
              idx   <= idx + AW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpu_pattern_player.sv
// Self-checking bench for fpu_pattern_player with a latency-accurate stand-in FPU.
module tb_fpu_pattern_player;

`ifdef FPU_PATTERN_FLAG_CHECK_EN
  localparam bit FLAG_EN = 1'b1;
`else
  localparam bit FLAG_EN = 1'b0;
`endif
  localparam int LAT = 4;

  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic         ld_valid = 1'b0;
  logic         ld_ready;
  logic [5:0]   ld_addr = '0;
  logic [101:0] ld_data = '0;
  logic         go = 1'b0;
  logic [6:0]   num_vec = '0;
  logic         abort = 1'b0;
  logic [31:0]  A, B, Y;
  logic [1:0]   Sel, round;
  logic         start, Error, Overflow, busy, done, pass;
  logic [15:0]  mis_cnt;
  logic [5:0]   fail_idx;

  int n_cmp = 0;
  int n_bad = 0;
  int st_cnt = 0;
  logic [67:0]  iss_q[$];
  logic [101:0] sm [64];
  bit           ovf_force = 1'b0;

  fpu_pattern_player dut (
    .Clock(Clock), .Reset(Reset), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data), .go(go), .num_vec(num_vec), .abort(abort),
    .A(A), .B(B), .Sel(Sel), .round(round), .start(start), .Y(Y), .Error(Error),
    .Overflow(Overflow), .busy(busy), .done(done), .pass(pass), .mis_cnt(mis_cnt),
    .fail_idx(fail_idx)
  );

  always #5 Clock = ~Clock;

  // Stand-in FPU arithmetic; ADD of equal operands doubles (exponent + 1)
  function automatic logic [31:0] fpu_y(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] s, input logic [1:0] r);
    case (s)
      2'd0:    fpu_y = (a == b) ? a + 32'h0080_0000 : a + b;
      2'd1:    fpu_y = a - b;
      2'd2:    fpu_y = a ^ {b[15:0], b[31:16]} ^ {30'd0, r};
      default: fpu_y = (b == 32'd0) ? 32'h7FC0_0000 : a + {r, 30'd0};
    endcase
  endfunction

  function automatic logic fpu_err(input logic [31:0] b, input logic [1:0] s);
    return (s == 2'd3) && (b == 32'd0);
  endfunction

  function automatic logic fpu_ovf(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s);
    return (s == 2'd0) && (a == b) && (a[30:23] == 8'hFE);
  endfunction

  // Result and flags appear exactly LAT cycles after start; junk otherwise
  logic [LAT-1:0] pv = '0;
  logic [LAT-1:0] pe = '0;
  logic [LAT-1:0] po = '0;
  logic [31:0]    py [LAT];
  always @(posedge Clock) begin
    pv    <= {pv[LAT-2:0], start};
    pe    <= {pe[LAT-2:0], fpu_err(B, Sel)};
    po    <= {po[LAT-2:0], fpu_ovf(A, B, Sel) | ovf_force};
    py[0] <= fpu_y(A, B, Sel, round);
    for (int i = 1; i < LAT; i++) py[i] <= py[i-1];
  end
  assign Y        = pv[LAT-1] ? py[LAT-1] : 32'hBAD0_BAD0;
  assign Error    = pv[LAT-1] ? pe[LAT-1] : 1'b1;
  assign Overflow = pv[LAT-1] ? po[LAT-1] : 1'b1;

  always @(negedge Clock) begin
    if (start) begin
      st_cnt++;
      iss_q.push_back({A, B, Sel, round});
    end
  end

  function automatic logic [101:0] mk(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s,
                                      input logic [1:0] r, input logic [31:0] y, input logic e, input logic o);
    return {a, b, s, r, y, e, o};
  endfunction

  function automatic logic [101:0] rand_vec(input bit bad_y, input bit bad_f);
    logic [31:0] a = $urandom;
    logic [31:0] b = $urandom;
    logic [1:0]  s = 2'($urandom_range(0, 3));
    logic [1:0]  r = 2'($urandom_range(0, 3));
    logic [31:0] y;
    if ($urandom_range(0, 3) == 0) b = a;
    if (s == 2'd3 && $urandom_range(0, 2) == 0) b = 32'd0;
    y = fpu_y(a, b, s, r);
    if (bad_y) y ^= 32'h1 << $urandom_range(0, 31);
    return mk(a, b, s, r, y, fpu_err(b, s) ^ bad_f, fpu_ovf(a, b, s));
  endfunction

  // Reference: a vector fails if the FPU's answer differs from what the slot expects
  function automatic bit vec_bad(input logic [101:0] v, input bit of);
    logic [31:0] a, b, y;
    logic [1:0]  s, r;
    logic        e, o;
    bit          flag_bad;
    {a, b, s, r, y, e, o} = v;
    flag_bad = (e != fpu_err(b, s)) || (o != (fpu_ovf(a, b, s) | of));
    return (y != fpu_y(a, b, s, r)) || (FLAG_EN && flag_bad);
  endfunction

  task automatic ref_run(input int n, output int mis, output int fi);
    mis = 0;
    fi  = 0;
    for (int i = 0; i < n; i++) begin
      if (vec_bad(sm[i], ovf_force)) begin
        if (mis == 0) fi = i;
        mis++;
      end
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic load(input int addr, input logic [101:0] d);
    ld_valid = 1'b1;
    ld_addr  = 6'(addr);
    ld_data  = d;
    step();
    ld_valid = 1'b0;
    sm[addr] = d;
  endtask

  task automatic run(input int n, output int cyc);
    st_cnt = 0;
    iss_q.delete();
    num_vec = 7'(n);
    go = 1'b1;
    step();
    go  = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 1000) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_cmp++;
    if ({ld_ready, busy, done, pass, start} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_ctrl got %b exp 10000", {ld_ready, busy, done, pass, start});
    end
    n_cmp++;
    if ({mis_cnt, fail_idx, A, B, Sel, round} !== '0) begin
      n_bad++;
      $display("FAIL reset_data got mis=%0d fi=%0d A=%h B=%h exp all zero", mis_cnt, fail_idx, A, B);
    end
    Reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    int cyc;
    load(0, mk(32'h3F80_0000, 32'h3F80_0000, 2'd0, 2'd0, 32'h4000_0000, 1'b0, 1'b0));
    run(1, cyc);
    n_cmp++;
    if (cyc != 1 * (LAT + 3) + 1) begin n_bad++; $display("FAIL single_latency got %0d exp %0d", cyc, LAT + 4); end
    n_cmp++;
    if (st_cnt != 1) begin n_bad++; $display("FAIL single_starts got %0d exp 1", st_cnt); end
    n_cmp++;
    if ({pass, mis_cnt, busy, ld_ready} !== {1'b1, 16'd0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL single_status got pass=%b mis=%0d busy=%b rdy=%b exp 1 0 0 1", pass, mis_cnt, busy, ld_ready);
    end
    n_cmp++;
    if (iss_q.size() != 1 || iss_q[0] !== {32'h3F80_0000, 32'h3F80_0000, 4'd0}) begin
      n_bad++;
      $display("FAIL single_issue got size %0d exp 1 with 1.0+1.0", iss_q.size());
    end
  endtask

  task automatic test_mismatch();
    int cyc;
    load(0, rand_vec(1'b0, 1'b0));
    load(1, mk(32'h3F80_0000, 32'h3F80_0000, 2'd0, 2'd0, 32'h4000_0001, 1'b0, 1'b0));
    load(2, rand_vec(1'b0, 1'b0));
    run(3, cyc);
    n_cmp++;
    if ({mis_cnt, fail_idx, pass} !== {16'd1, 6'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL mism_result got mis=%0d fi=%0d pass=%b exp 1 1 0", mis_cnt, fail_idx, pass);
    end
    n_cmp++;
    if (st_cnt != 3 || cyc != 3 * (LAT + 3) + 1) begin
      n_bad++;
      $display("FAIL mism_timing got starts=%0d cyc=%0d exp 3 %0d", st_cnt, cyc, 3 * (LAT + 3) + 1);
    end
  endtask

  task automatic test_zero();
    int cyc;
    run(0, cyc);
    n_cmp++;
    if (cyc != 1 || st_cnt != 0) begin n_bad++; $display("FAIL zero_timing got cyc=%0d starts=%0d exp 1 0", cyc, st_cnt); end
    n_cmp++;
    if ({pass, done, mis_cnt, fail_idx} !== {1'b1, 1'b1, 16'd0, 6'd0}) begin
      n_bad++;
      $display("FAIL zero_status got pass=%b done=%b mis=%0d fi=%0d exp 1 1 0 0", pass, done, mis_cnt, fail_idx);
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 4; i++) load(i, rand_vec(i == 0, 1'b0));
    st_cnt = 0;
    num_vec = 7'd4;
    go = 1'b1;
    for (int k = 1; k <= 2 * (LAT + 3) - 3; k++) begin step(); go = 1'b0; end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++;
    if ({busy, done, ld_ready, start} !== 4'b0010) begin
      n_bad++;
      $display("FAIL abort_ctrl got busy=%b done=%b rdy=%b start=%b exp 0 0 1 0", busy, done, ld_ready, start);
    end
    n_cmp++;
    if (mis_cnt !== 16'd1 || fail_idx !== 6'd0) begin
      n_bad++;
      $display("FAIL abort_kept got mis=%0d fi=%0d exp 1 0", mis_cnt, fail_idx);
    end
    repeat (30) step();
    n_cmp++;
    if (st_cnt != 2 || done !== 1'b0) begin n_bad++; $display("FAIL abort_quiet got starts=%0d done=%b exp 2 0", st_cnt, done); end
    go = 1'b1;
    abort = 1'b1;
    step();
    go = 1'b0;
    abort = 1'b0;
    repeat (10) step();
    n_cmp++;
    if (busy !== 1'b0 || st_cnt != 2 || mis_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL abort_beats_go got busy=%b starts=%0d mis=%0d exp 0 2 1", busy, st_cnt, mis_cnt);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, mis, fi;
    num_vec = 7'd4;
    go = 1'b1;
    step();
    go = 1'b0;
    step();
    n_cmp++;
    if (start !== 1'b1) begin n_bad++; $display("FAIL issue_start got %b exp 1", start); end
    #1 Reset = 1'b0;
    #1;
    n_cmp++;
    if ({start, busy, ld_ready, A} !== {1'b0, 1'b0, 1'b1, 32'd0}) begin
      n_bad++;
      $display("FAIL midreset got start=%b busy=%b rdy=%b A=%h exp 0 0 1 0", start, busy, ld_ready, A);
    end
    #2 Reset = 1'b1;
    step();
    run(4, cyc);
    ref_run(4, mis, fi);
    n_cmp++;
    if (mis_cnt !== 16'(mis) || fail_idx !== 6'(fi)) begin
      n_bad++;
      $display("FAIL mem_kept got mis=%0d fi=%0d exp %0d %0d", mis_cnt, fail_idx, mis, fi);
    end
  endtask

  task automatic test_load_while_busy();
    int cyc, mis, fi, first_mis;
    bit rdy_bad = 1'b0;
    for (int i = 0; i < 3; i++) load(i, rand_vec(i == 2, 1'b0));
    ref_run(3, mis, fi);
    run(3, cyc);
    first_mis = int'(mis_cnt);
    num_vec = 7'd3;
    go = 1'b1;
    step();
    go = 1'b0;
    ld_valid = 1'b1;
    ld_addr = 6'd1;
    ld_data = rand_vec(1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (ld_ready !== 1'b0) rdy_bad = 1'b1;
      step();
    end
    ld_valid = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin step(); cyc++; end
    n_cmp++;
    if (rdy_bad) begin n_bad++; $display("FAIL busy_ready got ld_ready=1 exp 0 while busy"); end
    run(3, cyc);
    n_cmp++;
    if (mis_cnt !== 16'(mis) || int'(mis_cnt) != first_mis) begin
      n_bad++;
      $display("FAIL busy_load_dropped got mis=%0d exp %0d", mis_cnt, mis);
    end
  endtask

  task automatic test_flags();
    int cyc, mis, fi;
    load(0, mk(32'h3F80_0000, 32'h3F80_0000, 2'd0, 2'd0, 32'h4000_0000, 1'b0, 1'b0));
    ovf_force = 1'b1;
    ref_run(1, mis, fi);
    run(1, cyc);
    ovf_force = 1'b0;
    n_cmp++;
    if (mis_cnt !== 16'(mis) || pass !== (mis == 0)) begin
      n_bad++;
      $display("FAIL flag_only got mis=%0d pass=%b exp %0d %b", mis_cnt, pass, mis, mis == 0);
    end
  endtask

  task automatic test_back_to_back();
    int n, cyc, mis, fi;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) load(i, rand_vec($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0));
      ref_run(n, mis, fi);
      run(n, cyc);
      n_cmp++;
      if (mis_cnt !== 16'(mis) || pass !== (mis == 0)) begin
        n_bad++;
        $display("FAIL rnd%0d_mis got mis=%0d pass=%b exp %0d %b", it, mis_cnt, pass, mis, mis == 0);
      end
      if (mis != 0) begin
        n_cmp++;
        if (fail_idx !== 6'(fi)) begin n_bad++; $display("FAIL rnd%0d_fail_idx got %0d exp %0d", it, fail_idx, fi); end
      end
      n_cmp++;
      if (cyc != n * (LAT + 3) + 1 || st_cnt != n) begin
        n_bad++;
        $display("FAIL rnd%0d_timing got cyc=%0d starts=%0d exp %0d %0d", it, cyc, st_cnt, n * (LAT + 3) + 1, n);
      end
      for (int i = 0; i < n && i < iss_q.size(); i++) begin
        n_cmp++;
        if (iss_q[i] !== sm[i][101:34]) begin
          n_bad++;
          $display("FAIL rnd%0d_issue%0d got %h exp %h", it, i, iss_q[i], sm[i][101:34]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mismatch();
    test_zero();
    test_abort();
    test_reset_mid_run();
    test_load_while_busy();
    test_flags();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
